// File: rtl/pkt_serial_rx.sv
// Tick-paced serial packet receiver: start/data/[parity]/stop framing into a FWFT buffer.
// Optional even-parity checking is enabled by defining PKT_SERIAL_RX_PARITY_EN.
module pkt_serial_rx #(
   parameter int PK_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            ser_in,
   input  logic            read_req,
   output logic [PK_W-1:0] recv_packet_in,
   output logic            recv_input_buffer_empty,
   output logic            recv_buffer_full,
   output logic            overflow,
   output logic            frame_err,
   output logic [1:0]      dbg_state
);

   localparam int CW = $clog2(PK_W);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(PK_W - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [PK_W-1:0]   shift_q, shift_d;
   logic [PK_W-1:0]   mem_q [DEPTH];
   logic [PK_W-1:0]   mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              frame_err_q, frame_err_d;
   logic              par_ok;
   logic              good_frame, push, pop;

`ifdef PKT_SERIAL_RX_PARITY_EN
   logic par_ok_q, par_ok_d;
   assign par_ok = par_ok_q;
`else
   assign par_ok = 1'b1;
`endif

   // Receive FSM: every state change is qualified by tick, so non-tick cycles hold all state.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      good_frame  = 1'b0;
      frame_err_d = 1'b0;
`ifdef PKT_SERIAL_RX_PARITY_EN
      par_ok_d    = par_ok_q;
`endif
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!ser_in) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d[bit_cnt_q] = ser_in;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef PKT_SERIAL_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
`ifdef PKT_SERIAL_RX_PARITY_EN
            PARITY: begin
               par_ok_d = ~((^shift_q) ^ ser_in);
               state_d  = STOP;
            end
`endif
            STOP: begin
               if (ser_in && par_ok) good_frame = 1'b1;
               else                  frame_err_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Buffer handshake: a pop happens on any edge where read_req=1 and the buffer is
   // non-empty; read_req while empty is ignored. The head is valid whenever empty=0.
   always_comb begin
      pop        = read_req && (count_q != '0);
      push       = good_frame && (!recv_buffer_full || pop);
      overflow_d = good_frame && recv_buffer_full && !pop;
      mem_d      = mem_q;
      if (push) mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q   <= mem_d;
      shift_q <= shift_d;
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PKT_SERIAL_RX_PARITY_EN
         par_ok_q    <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
`ifdef PKT_SERIAL_RX_PARITY_EN
         par_ok_q    <= par_ok_d;
`endif
      end
   end

   assign recv_input_buffer_empty = (count_q == '0);
   assign recv_buffer_full        = (count_q == FULL_CNT);
   assign recv_packet_in          = recv_input_buffer_empty ? '0 : mem_q[rd_ptr_q];
   assign overflow                = overflow_q;
   assign frame_err               = frame_err_q;
   assign dbg_state               = state_q;

endmodule
